// File: rtl/cache_pkg.sv
// Shared types and constants for the cache <-> physical memory adapter.
package cache_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned S_LINE   = 256;
    localparam int unsigned S_BURST  = 64;
    localparam int unsigned S_OFFSET = 5;
    localparam int unsigned BEATS    = S_LINE / S_BURST;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } adapter_state_t;

    // Mask that clears the in-line byte offset of an address.
    function automatic logic [ADDR_W-1:0] line_addr_mask(input int unsigned offset);
        logic [ADDR_W-1:0] m;
        m = '1;
        return m << offset;
    endfunction

    localparam logic [ADDR_W-1:0] LINE_ADDR_MASK = line_addr_mask(S_OFFSET);

endpackage

// File: rtl/line_buffer.sv
// Line-wide holding register: whole-line load, per-beat load, per-beat read.
module line_buffer
    import cache_pkg::*;
#(
    parameter int unsigned LINE_W = S_LINE,
    parameter int unsigned BEAT_W = S_BURST,
    localparam int unsigned IDX_W = $clog2(LINE_W / BEAT_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load_line,
    input  logic [LINE_W-1:0] i_line,
    input  logic              i_load_beat,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [BEAT_W-1:0] i_beat,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [BEAT_W-1:0] o_rd_beat_c,
    output logic [LINE_W-1:0] o_line
);

    logic [LINE_W-1:0] r_line;

    // Full-line load takes priority; otherwise deposit one beat at its slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line <= '0;
        end else if (i_load_line) begin
            r_line <= i_line;
        end else if (i_load_beat) begin
            r_line[int'(i_wr_idx)*BEAT_W +: BEAT_W] <= i_beat;
        end
    end

    assign o_rd_beat_c = r_line[int'(i_rd_idx)*BEAT_W +: BEAT_W];
    assign o_line      = r_line;

endmodule

// File: rtl/cacheline_adapter.sv
// Serves one cache-line read/write as a 4-beat burst to physical memory.
module cacheline_adapter
    import cache_pkg::*;
#(
    parameter int unsigned s_line   = S_LINE,
    parameter int unsigned s_burst  = S_BURST,
    parameter int unsigned s_offset = S_OFFSET
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               line_read_i,
    input  logic               line_write_i,
    input  logic [ADDR_W-1:0]  line_address_i,
    input  logic [s_line-1:0]  line_wdata_i,
    output logic [s_line-1:0]  line_rdata_o,
    output logic               line_resp_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic [ADDR_W-1:0]  mem_address_o,
    output logic [s_burst-1:0] mem_wdata_o,
    input  logic [s_burst-1:0] mem_rdata_i,
    input  logic               mem_resp_i
);

    localparam int unsigned NBEATS = s_line / s_burst;
    localparam int unsigned CNT_W  = $clog2(NBEATS);
    localparam logic [ADDR_W-1:0] ADDR_MASK = line_addr_mask(s_offset);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(NBEATS - 1);

    adapter_state_t     r_state;
    adapter_state_t     w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_mem_read;
    logic               r_mem_write;
    logic               r_line_resp;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [s_burst-1:0] r_mem_wdata;
    logic               w_mem_read_next;
    logic               w_mem_write_next;
    logic               w_line_resp_next;
    logic [ADDR_W-1:0]  w_mem_addr_next;
    logic [s_burst-1:0] w_mem_wdata_next;
    logic               w_load_line;
    logic               w_load_beat;
    logic [CNT_W-1:0]   w_rd_idx;
    logic [s_burst-1:0] w_rd_beat;
    logic [s_line-1:0]  w_line;

    // Next write beat is pre-fetched so mem_wdata_o can be a plain register.
    assign w_rd_idx = CNT_W'(r_cnt + 1'b1);

    line_buffer #(
        .LINE_W (s_line),
        .BEAT_W (s_burst)
    ) u_line_buffer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load_line (w_load_line),
        .i_line      (line_wdata_i),
        .i_load_beat (w_load_beat),
        .i_wr_idx    (r_cnt),
        .i_beat      (mem_rdata_i),
        .i_rd_idx    (w_rd_idx),
        .o_rd_beat_c (w_rd_beat),
        .o_line      (w_line)
    );

    // State, beat counter and registered memory-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_line_resp <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_mem_read  <= w_mem_read_next;
            r_mem_write <= w_mem_write_next;
            r_line_resp <= w_line_resp_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
        end
    end

    // Next-state and next-output decode; write wins over read in IDLE.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_mem_read_next  = 1'b0;
        w_mem_write_next = 1'b0;
        w_line_resp_next = 1'b0;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_load_line      = 1'b0;
        w_load_beat      = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_next       = '0;
                w_mem_addr_next  = '0;
                w_mem_wdata_next = '0;
                if (line_write_i) begin
                    w_state_next     = WRITE;
                    w_load_line      = 1'b1;
                    w_mem_write_next = 1'b1;
                    w_mem_addr_next  = line_address_i & ADDR_MASK;
                    w_mem_wdata_next = line_wdata_i[s_burst-1:0];
                end else if (line_read_i) begin
                    w_state_next     = READ;
                    w_mem_read_next  = 1'b1;
                    w_mem_addr_next  = line_address_i & ADDR_MASK;
                end
            end
            READ: begin
                w_mem_read_next = 1'b1;
                if (mem_resp_i) begin
                    w_load_beat = 1'b1;
                    w_cnt_next  = CNT_W'(r_cnt + 1'b1);
                    if (r_cnt == LAST_BEAT) begin
                        w_state_next     = DONE;
                        w_mem_read_next  = 1'b0;
                        w_line_resp_next = 1'b1;
                    end
                end
            end
            WRITE: begin
                w_mem_write_next = 1'b1;
                if (mem_resp_i) begin
                    w_cnt_next       = CNT_W'(r_cnt + 1'b1);
                    w_mem_wdata_next = w_rd_beat;
                    if (r_cnt == LAST_BEAT) begin
                        w_state_next     = DONE;
                        w_mem_write_next = 1'b0;
                        w_line_resp_next = 1'b1;
                        w_mem_wdata_next = '0;
                    end
                end
            end
            DONE: begin
                w_state_next    = IDLE;
                w_cnt_next      = '0;
                w_mem_addr_next = '0;
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign line_rdata_o  = w_line;
    assign line_resp_o   = r_line_resp;
    assign mem_read_o    = r_mem_read;
    assign mem_write_o   = r_mem_write;
    assign mem_address_o = r_mem_addr;
    assign mem_wdata_o   = r_mem_wdata;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Bench: transaction-level model of the line adapter driven by a random memory responder.
module tb_cacheline_adapter;

    logic         clk;
    logic         rst_n;
    logic         line_read_i;
    logic         line_write_i;
    logic [31:0]  line_address_i;
    logic [255:0] line_wdata_i;
    logic [255:0] line_rdata_o;
    logic         line_resp_o;
    logic         mem_read_o;
    logic         mem_write_o;
    logic [31:0]  mem_address_o;
    logic [63:0]  mem_wdata_o;
    logic [63:0]  mem_rdata_i;
    logic         mem_resp_i;

    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;
    logic [255:0] exp_line;

    cacheline_adapter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .line_read_i    (line_read_i),
        .line_write_i   (line_write_i),
        .line_address_i (line_address_i),
        .line_wdata_i   (line_wdata_i),
        .line_rdata_o   (line_rdata_o),
        .line_resp_o    (line_resp_o),
        .mem_read_o     (mem_read_o),
        .mem_write_o    (mem_write_o),
        .mem_address_o  (mem_address_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .mem_resp_i     (mem_resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // One line transaction from sample edge through the first IDLE cycle.
    // pat bit k says whether memory answers in the k-th cycle after sampling.
    task automatic run_txn(input bit is_wr, input bit hold_rd, input logic [31:0] addr,
                           input logic [255:0] line, input logic [31:0] pat);
        int taken;
        int cyc;
        bit rsp;
        line_address_i = addr;
        line_wdata_i   = is_wr ? line : rand_line();
        line_write_i   = is_wr;
        line_read_i    = !is_wr || hold_rd;
        @(posedge clk);
        taken = 0;
        cyc   = 0;
        while (taken < 4 && cyc < 64) begin
            @(negedge clk);
            line_address_i = $urandom;
            line_wdata_i   = rand_line();
            check_eq("mem_read", 256'(mem_read_o), 256'(!is_wr));
            check_eq("mem_write", 256'(mem_write_o), 256'(is_wr));
            check_eq("mem_address", 256'(mem_address_o), 256'(addr & 32'hFFFF_FFE0));
            check_eq("resp_early", 256'(line_resp_o), 256'(0));
            if (is_wr) check_eq("mem_wdata", 256'(mem_wdata_o), 256'(line[taken*64 +: 64]));
            rsp = (cyc >= 32) ? 1'b1 : pat[cyc];
            mem_resp_i  = rsp;
            mem_rdata_i = rsp ? line[taken*64 +: 64] : {$urandom, $urandom};
            @(posedge clk);
            if (rsp) taken++;
            cyc++;
        end
        // Response cycle: stray memory handshake must be ignored here.
        @(negedge clk);
        line_write_i = 1'b0;
        line_read_i  = hold_rd;
        mem_resp_i   = 1'b1;
        mem_rdata_i  = {$urandom, $urandom};
        exp_line     = line;
        check_eq("line_resp", 256'(line_resp_o), 256'(1));
        check_eq("done_mem_read", 256'(mem_read_o), 256'(0));
        check_eq("done_mem_write", 256'(mem_write_o), 256'(0));
        check_eq("line_rdata", line_rdata_o, exp_line);
        @(posedge clk);
        @(negedge clk);
        mem_resp_i  = 1'($urandom);
        mem_rdata_i = {$urandom, $urandom};
        check_eq("resp_single", 256'(line_resp_o), 256'(0));
        check_eq("idle_mem_read", 256'(mem_read_o), 256'(0));
        check_eq("idle_mem_write", 256'(mem_write_o), 256'(0));
        check_eq("idle_address", 256'(mem_address_o), 256'(0));
        check_eq("idle_rdata_hold", line_rdata_o, exp_line);
    endtask

    initial begin
        logic [255:0] l;
        rst_n          = 1'b0;
        line_read_i    = 1'b0;
        line_write_i   = 1'b0;
        line_address_i = '0;
        line_wdata_i   = '0;
        mem_rdata_i    = '0;
        mem_resp_i     = 1'b0;
        exp_line       = '0;
        #12;
        check_eq("rst_line_resp", 256'(line_resp_o), 256'(0));
        check_eq("rst_mem_read", 256'(mem_read_o), 256'(0));
        check_eq("rst_mem_write", 256'(mem_write_o), 256'(0));
        check_eq("rst_mem_address", 256'(mem_address_o), 256'(0));
        check_eq("rst_mem_wdata", 256'(mem_wdata_o), 256'(0));
        check_eq("rst_line_rdata", line_rdata_o, 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Read, memory answering every cycle.
        l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        run_txn(1'b0, 1'b0, 32'h0000_1234, l, 32'hFFFF_FFFF);

        // Write with handshake gaps 1,0,1,0,0,1,1.
        run_txn(1'b1, 1'b0, 32'h0000_5678, rand_line(), 32'h0000_0065);

        // Read and write together: write first, read follows with read held.
        run_txn(1'b1, 1'b1, 32'hABCD_0040, rand_line(), $urandom);
        run_txn(1'b0, 1'b0, 32'hABCD_0040, rand_line(), $urandom);

        // Back-to-back reads.
        run_txn(1'b0, 1'b0, 32'h0000_0040, rand_line(), 32'hFFFF_FFFF);
        run_txn(1'b0, 1'b0, 32'h0000_0060, rand_line(), 32'hFFFF_FFFF);

        // Reset in the middle of a read after two beats.
        line_address_i = 32'h0000_0100;
        line_read_i    = 1'b1;
        @(posedge clk);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            mem_resp_i  = 1'b1;
            mem_rdata_i = {$urandom, $urandom};
            @(posedge clk);
        end
        @(negedge clk);
        mem_resp_i = 1'b0;
        check_eq("pre_rst_mem_read", 256'(mem_read_o), 256'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_mem_read", 256'(mem_read_o), 256'(0));
        check_eq("mid_rst_line_resp", 256'(line_resp_o), 256'(0));
        check_eq("mid_rst_address", 256'(mem_address_o), 256'(0));
        check_eq("mid_rst_rdata", line_rdata_o, 256'(0));
        line_read_i = 1'b0;
        @(negedge clk);
        check_eq("rst_hold_resp", 256'(line_resp_o), 256'(0));
        rst_n    = 1'b1;
        exp_line = '0;
        @(negedge clk);
        check_eq("post_rst_resp", 256'(line_resp_o), 256'(0));
        run_txn(1'b0, 1'b0, 32'h0000_0100, rand_line(), $urandom);

        // Random mix of reads and writes with random handshake gaps.
        for (int t = 0; t < 24; t++) begin
            run_txn(1'($urandom), 1'b0, $urandom, rand_line(), $urandom | $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
